wptr_ctrl: RTL

Write-side pointer and status controller for the async FIFO, parametrised in depth.
- Generates binary and Gray write pointers and the RAM write address.
- Produces registered full, almost-full, half-full and fill-level status from the read pointer synchronised into wclk.
- Adds a sticky overflow flag and a runtime-programmable almost-full threshold.
- Sits between the write client, the dual-port RAM and the wclk-domain read-pointer synchroniser.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/wptr_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the default pointer type.
package fifo_pkg;

    localparam int unsigned FUNC_W         = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned PTR_W_DEF      = ADDR_WIDTH_DEF + 1;

    typedef logic [PTR_W_DEF-1:0] ptr_t;

    function automatic logic [FUNC_W-1:0] width_mask(input int unsigned w);
        return (w >= FUNC_W) ? '1 : ((FUNC_W'(1) << w) - FUNC_W'(1));
    endfunction

    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b,
                                                   input int unsigned w);
        logic [FUNC_W-1:0] v;
        v = b & width_mask(w);
        return v ^ (v >> 1);
    endfunction

    // Prefix XOR from the MSB down, done by log-step doubling.
    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g,
                                                   input int unsigned w);
        logic [FUNC_W-1:0] r;
        r = g & width_mask(w);
        for (int s = 1; s < int'(FUNC_W); s = s * 2) begin
            r = r ^ (r >> s);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchroniser with async active-low reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wptr_ctrl.sv
// Async FIFO write-side pointer/status controller.
// Define WPTR_SYNC_EN to synchronise g_rptr_sync internally with sync_2ff.
module wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AFULL_RST  = (2 ** ADDR_WIDTH) - 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH:0]   g_rptr_sync,
    input  logic                  afull_wr,
    input  logic [ADDR_WIDTH:0]   afull_thresh_in,
    input  logic                  ovf_clr,
    output logic                  w_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   b_wptr,
    output logic [ADDR_WIDTH:0]   g_wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic                  half_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  overflow
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [PTR_W-1:0] wptr_t;

    localparam wptr_t DEPTH_P    = PTR_W'(DEPTH);
    localparam wptr_t HALF_P     = PTR_W'(DEPTH / 2);
    localparam wptr_t THRESH_RST = (AFULL_RST > DEPTH) ? DEPTH_P : PTR_W'(AFULL_RST);

    wptr_t g_rsync;
    wptr_t b_rsync;
    wptr_t b_next;
    wptr_t g_next;
    wptr_t lvl_next;
    wptr_t thresh;
    wptr_t thresh_next;
    logic  full_next;
    logic  afull_next;
    logic  half_next;
    logic  ovf_next;

`ifdef WPTR_SYNC_EN
    sync_2ff #(
        .WIDTH (PTR_W)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (g_rptr_sync),
        .q     (g_rsync)
    );
`else
    assign g_rsync = g_rptr_sync;
`endif

    // Writes are blocked while full and while reset is held.
    assign w_accept = w_en & ~full & wrst_n;
    assign waddr    = b_wptr[ADDR_WIDTH-1:0];

    // Next pointers, level and flags.
    always_comb begin
        b_next      = b_wptr;
        g_next      = g_wptr;
        b_rsync     = '0;
        lvl_next    = '0;
        thresh_next = thresh;
        full_next   = 1'b0;
        afull_next  = 1'b0;
        half_next   = 1'b0;
        ovf_next    = overflow;

        b_next   = b_wptr + PTR_W'(w_accept);
        g_next   = PTR_W'(bin2gray(FUNC_W'(b_next), PTR_W));
        b_rsync  = PTR_W'(gray2bin(FUNC_W'(g_rsync), PTR_W));
        lvl_next = b_next - b_rsync;

        // Full when the write pointer is one lap ahead of the read pointer.
        full_next  = (g_next == {~g_rsync[PTR_W-1:PTR_W-2], g_rsync[PTR_W-3:0]});
        afull_next = (lvl_next >= thresh);
        half_next  = (lvl_next >= HALF_P);

        if (afull_wr) begin
            thresh_next = (afull_thresh_in > DEPTH_P) ? DEPTH_P : afull_thresh_in;
        end

        // A new overflow wins over a clear on the same edge.
        ovf_next = (w_en & full) | (overflow & ~ovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            wlevel      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            half_full   <= 1'b0;
            overflow    <= 1'b0;
            thresh      <= THRESH_RST;
        end else begin
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            wlevel      <= lvl_next;
            full        <= full_next;
            almost_full <= afull_next;
            half_full   <= half_next;
            overflow    <= ovf_next;
            thresh      <= thresh_next;
        end
    end

endmodule
